tcdm_rr_arbiter: RTL and testbench

- Shares one TCDM memory port between N_REQ requesters (core data port, RedMulE streamer ports) using round-robin arbitration.
- Tracks outstanding transactions in an ID FIFO and routes each r_valid/r_data back to the requester that issued it.
- Sits between the requesters and a tb_tcdm-style memory bank, replacing static address-priority muxing.

---
 rtl/tcdm_rr_arbiter_if.sv | 45 ++++
 rtl/tcdm_rr_arbiter.sv | 155 +++++++++++++++
 tb/tb_tcdm_rr_arbiter.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tcdm_rr_arbiter_if.sv
// Bus bundle between N_REQ TCDM requesters, the round-robin arbiter and one memory port.
// Names match the arbiter's flat port list so existing requester/memory wiring maps one-to-one.

// Handshake: a requester raises req with a stable payload and holds both until gnt;
// a transfer happens on req & gnt in the same cycle, gnt being combinational. r_valid is a
// single-cycle pulse with no back-pressure, returned in issue order for reads and writes alike.
interface tcdm_rr_arbiter_if #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
);
  logic [N_REQ-1:0]        req_i;
  logic [N_REQ*AW-1:0]     add_i;
  logic [N_REQ-1:0]        wen_i;
  logic [N_REQ*DW/8-1:0]   be_i;
  logic [N_REQ*DW-1:0]     data_i;
  logic [N_REQ-1:0]        gnt_o;
  logic [N_REQ*DW-1:0]     r_data_o;
  logic [N_REQ-1:0]        r_valid_o;

  logic                    mem_req_o;
  logic [AW-1:0]           mem_add_o;
  logic                    mem_wen_o;
  logic [DW/8-1:0]         mem_be_o;
  logic [DW-1:0]           mem_data_o;
  logic                    mem_gnt_i;
  logic [DW-1:0]           mem_r_data_i;
  logic                    mem_r_valid_i;

  // Arbiter view.
  modport slave (
    input  req_i, add_i, wen_i, be_i, data_i,
    output gnt_o, r_data_o, r_valid_o,
    output mem_req_o, mem_add_o, mem_wen_o, mem_be_o, mem_data_o,
    input  mem_gnt_i, mem_r_data_i, mem_r_valid_i
  );

  // Environment view: requesters plus the memory bank.
  modport master (
    output req_i, add_i, wen_i, be_i, data_i,
    input  gnt_o, r_data_o, r_valid_o,
    input  mem_req_o, mem_add_o, mem_wen_o, mem_be_o, mem_data_o,
    output mem_gnt_i, mem_r_data_i, mem_r_valid_i
  );
endinterface

// File: rtl/tcdm_rr_arbiter.sv
// Round-robin arbiter sharing one TCDM port among N_REQ requesters; an ID FIFO of issuer
// indices routes each in-order memory response back to the requester that issued it.
module tcdm_rr_arbiter #(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  tcdm_rr_arbiter_if.slave               bus,
  output logic [$clog2(MAX_OUTST+1)-1:0] outst_o,
  output logic                           err_o
);

  localparam int unsigned PW = $clog2(N_REQ);
  localparam int unsigned FW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned CW = $clog2(MAX_OUTST + 1);
  localparam int unsigned BW = DW / 8;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] id_q [MAX_OUTST];
  logic [PW-1:0] id_d [MAX_OUTST];
  logic [FW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic          any_req;
  logic [PW-1:0] win;
  logic [PW:0]   scan_sum;
  logic [PW-1:0] scan_idx;
  logic          can_issue;
  logic          mem_req;
  logic          push;
  logic          pop;
  logic          spurious;
  logic [PW-1:0] head;

  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    r_valid;
  logic [N_REQ*DW-1:0] r_data;
  logic [AW-1:0]       mem_add;
  logic                mem_wen;
  logic [BW-1:0]       mem_be;
  logic [DW-1:0]       mem_data;

  // First asserted request at or after ptr_q, wrapping modulo N_REQ.
  always_comb begin
    any_req  = 1'b0;
    win      = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      scan_sum = {1'b0, ptr_q} + (PW+1)'(i);
      if (scan_sum >= (PW+1)'(N_REQ)) begin
        scan_sum = scan_sum - (PW+1)'(N_REQ);
      end
      scan_idx = scan_sum[PW-1:0];
      if (!any_req && bus.req_i[scan_idx]) begin
        any_req = 1'b1;
        win     = scan_idx;
      end
    end
  end

  // A response retiring this cycle frees its slot for a same-cycle issue.
  assign can_issue = (cnt_q < CW'(MAX_OUTST)) | bus.mem_r_valid_i;
  assign mem_req   = rst_ni & any_req & can_issue;
  assign push      = mem_req & bus.mem_gnt_i;
  assign pop       = rst_ni & bus.mem_r_valid_i & (cnt_q != '0);
  assign spurious  = bus.mem_r_valid_i & (cnt_q == '0) & ~push;
  assign head      = id_q[rd_ptr_q];

  always_comb begin
    mem_add  = '0;
    mem_wen  = 1'b1;
    mem_be   = '0;
    mem_data = '0;
    gnt      = '0;
    r_valid  = '0;
    r_data   = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (any_req && (win == PW'(i))) begin
        mem_add  = bus.add_i[i*AW +: AW];
        mem_wen  = bus.wen_i[i];
        mem_be   = bus.be_i[i*BW +: BW];
        mem_data = bus.data_i[i*DW +: DW];
        gnt[i]   = push;
      end
      if (pop && (head == PW'(i))) begin
        r_valid[i]          = 1'b1;
        r_data[i*DW +: DW]  = bus.mem_r_data_i;
      end
    end
  end

  always_comb begin
    ptr_d    = ptr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    err_d    = err_q | spurious;
    for (int k = 0; k < int'(MAX_OUTST); k++) begin
      id_d[k] = id_q[k];
    end
    if (push) begin
      ptr_d            = (win == PW'(N_REQ - 1)) ? '0 : win + PW'(1);
      id_d[wr_ptr_q]   = win;
      wr_ptr_d         = (wr_ptr_q == FW'(MAX_OUTST - 1)) ? '0 : wr_ptr_q + FW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == FW'(MAX_OUTST - 1)) ? '0 : rd_ptr_q + FW'(1);
    end
    if (push && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      for (int k = 0; k < int'(MAX_OUTST); k++) begin
        id_q[k] <= '0;
      end
    end else begin
      ptr_q    <= ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      for (int k = 0; k < int'(MAX_OUTST); k++) begin
        id_q[k] <= id_d[k];
      end
    end
  end

  assign bus.gnt_o      = gnt;
  assign bus.r_valid_o  = r_valid;
  assign bus.r_data_o   = r_data;
  assign bus.mem_req_o  = mem_req;
  assign bus.mem_add_o  = mem_add;
  assign bus.mem_wen_o  = mem_wen;
  assign bus.mem_be_o   = mem_be;
  assign bus.mem_data_o = mem_data;
  assign outst_o        = cnt_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_tcdm_rr_arbiter.sv
// Bench for tcdm_rr_arbiter: per-lane requester queues, a latency-configurable memory bank,
// a cycle model of the arbiter and a response scoreboard keyed by issuing lane.
module tb_tcdm_rr_arbiter;
  localparam int N_REQ     = 2;
  localparam int AW        = 32;
  localparam int DW        = 32;
  localparam int MAX_OUTST = 2;
  localparam int BW        = DW / 8;

  typedef struct {
    logic [AW-1:0] add;
    logic          wen;
    logic [BW-1:0] be;
    logic [DW-1:0] data;
  } txn_t;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } mresp_t;

  // ---------------- clock / reset ----------------
  logic       clk_i  = 1'b0;
  logic       rst_ni = 1'b0;
  logic [1:0] outst_o;
  logic       err_o;

  always #5 clk_i = ~clk_i;

  tcdm_rr_arbiter_if #(.N_REQ(N_REQ), .AW(AW), .DW(DW)) bus ();

  tcdm_rr_arbiter #(.N_REQ(N_REQ), .AW(AW), .DW(DW), .MAX_OUTST(MAX_OUTST)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .bus     (bus),
    .outst_o (outst_o),
    .err_o   (err_o)
  );

  // ---------------- bench state ----------------
  int n_chk  = 0;
  int n_pass = 0;

  txn_t          lq0[$];
  txn_t          lq1[$];
  logic [40:0]   exp_q[$];             // {lane[7:0], is_read, read data}
  logic [DW-1:0] ref_arr[logic [AW-1:0]];
  logic [DW-1:0] mem_arr[logic [AW-1:0]];
  mresp_t        mq[$];
  int            mem_lat = 1;
  bit            spur    = 1'b0;
  int            cyc     = 0;

  int m_ptr   = 0;
  int m_outst = 0;
  bit m_err   = 1'b0;

  logic [N_REQ-1:0]    gnt_log[$];
  logic [N_REQ-1:0]    rv_log[$];
  logic [1:0]          outst_log[$];
  logic                err_log[$];
  logic [N_REQ*DW-1:0] rdata_log[$];

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  // ---------------- memory bank ----------------
  logic [DW-1:0] mword;
  initial begin
    bus.mem_r_valid_i = 1'b0;
    bus.mem_r_data_i  = '0;
    forever begin
      @(posedge clk_i);
      cyc++;
      if (!rst_ni) begin
        mq.delete();
      end else if (bus.mem_req_o && bus.mem_gnt_i) begin
        mword = mem_arr.exists(bus.mem_add_o) ? mem_arr[bus.mem_add_o] : init_word(bus.mem_add_o);
        if (!bus.mem_wen_o) begin
          for (int b = 0; b < BW; b++) begin
            if (bus.mem_be_o[b]) mword[8*b +: 8] = bus.mem_data_o[8*b +: 8];
          end
          mem_arr[bus.mem_add_o] = mword;
          mq.push_back('{cyc + mem_lat - 1, '0});
        end else begin
          mq.push_back('{cyc + mem_lat - 1, mword});
        end
      end
      #2;
      if (!rst_ni) begin
        bus.mem_r_valid_i = 1'b0;
        bus.mem_r_data_i  = '0;
        spur              = 1'b0;
      end else if (spur) begin
        bus.mem_r_valid_i = 1'b1;
        bus.mem_r_data_i  = 32'hDEAD_0BAD;
        spur              = 1'b0;
      end else if (mq.size() > 0 && mq[0].due <= cyc) begin
        bus.mem_r_valid_i = 1'b1;
        bus.mem_r_data_i  = mq[0].data;
        void'(mq.pop_front());
      end else begin
        bus.mem_r_valid_i = 1'b0;
        bus.mem_r_data_i  = '0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_inputs();
    bus.req_i  = '0;
    bus.add_i  = '0;
    bus.wen_i  = '1;
    bus.be_i   = '0;
    bus.data_i = '0;
    if (lq0.size() > 0) begin
      bus.req_i[0]         = 1'b1;
      bus.add_i[0 +: AW]   = lq0[0].add;
      bus.wen_i[0]         = lq0[0].wen;
      bus.be_i[0 +: BW]    = lq0[0].be;
      bus.data_i[0 +: DW]  = lq0[0].data;
    end
    if (lq1.size() > 0) begin
      bus.req_i[1]         = 1'b1;
      bus.add_i[AW +: AW]  = lq1[0].add;
      bus.wen_i[1]         = lq1[0].wen;
      bus.be_i[BW +: BW]   = lq1[0].be;
      bus.data_i[DW +: DW] = lq1[0].data;
    end
  endtask

  task automatic clear_logs();
    gnt_log.delete(); rv_log.delete(); outst_log.delete(); err_log.delete(); rdata_log.delete();
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    lq0.delete();
    lq1.delete();
    drive_inputs();
    exp_q.delete();
    m_ptr = 0; m_outst = 0; m_err = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  // One clock: check against the cycle model at negedge, then advance requesters.
  task automatic tick();
    int               w;
    int               lane;
    logic             exp_req, exp_hs, exp_pop;
    logic [N_REQ-1:0] exp_gnt, obs_gnt;
    logic [40:0]      e;
    txn_t             t;
    logic [DW-1:0]    rd, wr;
    @(negedge clk_i);
    w = -1;
    for (int i = 0; i < N_REQ; i++) begin
      int j;
      j = (m_ptr + i) % N_REQ;
      if (w < 0 && bus.req_i[j]) w = j;
    end
    exp_req = (w >= 0) && ((m_outst < MAX_OUTST) || bus.mem_r_valid_i);
    exp_hs  = exp_req && bus.mem_gnt_i;
    exp_gnt = '0;
    if (exp_hs) exp_gnt[w] = 1'b1;
    obs_gnt = bus.gnt_o;
    gnt_log.push_back(obs_gnt);
    rv_log.push_back(bus.r_valid_o);
    outst_log.push_back(outst_o);
    err_log.push_back(err_o);
    rdata_log.push_back(bus.r_data_o);

    n_chk++;
    if (obs_gnt !== exp_gnt) $display("FAIL gnt cyc %0d: got %b expected %b", cyc, obs_gnt, exp_gnt);
    else n_pass++;
    n_chk++;
    if (bus.mem_req_o !== exp_req) $display("FAIL mem_req cyc %0d: got %b expected %b", cyc, bus.mem_req_o, exp_req);
    else n_pass++;
    n_chk++;
    if (outst_o !== 2'(m_outst)) $display("FAIL outst cyc %0d: got %0d expected %0d", cyc, outst_o, m_outst);
    else n_pass++;
    n_chk++;
    if (err_o !== m_err) $display("FAIL err cyc %0d: got %b expected %b", cyc, err_o, m_err);
    else n_pass++;

    exp_pop = bus.mem_r_valid_i && (m_outst > 0);
    if (exp_pop) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard cyc %0d: response with empty expected queue", cyc);
      end else begin
        e    = exp_q.pop_front();
        lane = int'(e[40:33]);
        if (bus.r_valid_o !== 2'(1 << lane))
          $display("FAIL r_valid cyc %0d: got %b expected %b", cyc, bus.r_valid_o, 2'(1 << lane));
        else n_pass++;
        if (e[32]) begin
          n_chk++;
          if (bus.r_data_o[lane*DW +: DW] !== e[31:0])
            $display("FAIL r_data lane %0d cyc %0d: got %h expected %h", lane, cyc, bus.r_data_o[lane*DW +: DW], e[31:0]);
          else n_pass++;
        end
      end
    end else begin
      n_chk++;
      if (bus.r_valid_o !== '0) $display("FAIL r_valid idle cyc %0d: got %b expected 00", cyc, bus.r_valid_o);
      else n_pass++;
    end

    if (bus.mem_r_valid_i && m_outst == 0 && !exp_hs) m_err = 1'b1;
    if (exp_hs) begin
      t  = (w == 0) ? lq0[0] : lq1[0];
      rd = ref_arr.exists(t.add) ? ref_arr[t.add] : init_word(t.add);
      if (!t.wen) begin
        wr = rd;
        for (int b = 0; b < BW; b++) if (t.be[b]) wr[8*b +: 8] = t.data[8*b +: 8];
        ref_arr[t.add] = wr;
      end
      exp_q.push_back({8'(w), t.wen, t.wen ? rd : 32'h0});
      m_ptr = (w + 1) % N_REQ;
    end
    if (exp_hs && !exp_pop) m_outst++;
    else if (exp_pop && !exp_hs) m_outst--;

    @(posedge clk_i);
    #1;
    if (obs_gnt[0] && lq0.size() > 0) void'(lq0.pop_front());
    if (obs_gnt[1] && lq1.size() > 0) void'(lq1.pop_front());
    drive_inputs();
  endtask

  task automatic drain();
    int k = 0;
    while ((lq0.size() > 0 || lq1.size() > 0 || m_outst > 0 || exp_q.size() > 0) && k < 100) begin
      tick();
      k++;
    end
    n_chk++;
    if (k >= 100) $display("FAIL drain timeout: %0d outstanding, %0d expected left", m_outst, exp_q.size());
    else n_pass++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.mem_gnt_i = 1'b1;
    drive_inputs();
    #3;
    n_chk++; if (bus.gnt_o !== '0) $display("FAIL rst_gnt: got %b expected 00", bus.gnt_o); else n_pass++;
    n_chk++; if (bus.r_valid_o !== '0) $display("FAIL rst_rvalid: got %b expected 00", bus.r_valid_o); else n_pass++;
    n_chk++; if (bus.r_data_o !== '0) $display("FAIL rst_rdata: got %h expected 0", bus.r_data_o); else n_pass++;
    n_chk++; if (bus.mem_req_o !== 1'b0) $display("FAIL rst_mem_req: got %b expected 0", bus.mem_req_o); else n_pass++;
    n_chk++; if (bus.mem_wen_o !== 1'b1) $display("FAIL rst_mem_wen: got %b expected 1", bus.mem_wen_o); else n_pass++;
    n_chk++; if (bus.mem_add_o !== '0) $display("FAIL rst_mem_add: got %h expected 0", bus.mem_add_o); else n_pass++;
    n_chk++; if (outst_o !== 2'd0) $display("FAIL rst_outst: got %0d expected 0", outst_o); else n_pass++;
    n_chk++; if (err_o !== 1'b0) $display("FAIL rst_err: got %b expected 0", err_o); else n_pass++;
    lq0.push_back('{32'h0000_0040, 1'b1, 4'hF, 32'h0});
    drive_inputs();
    #1;
    n_chk++; if (bus.mem_req_o !== 1'b0) $display("FAIL rst_req_held: got %b expected 0", bus.mem_req_o); else n_pass++;
    n_chk++; if (bus.gnt_o !== '0) $display("FAIL rst_gnt_held: got %b expected 00", bus.gnt_o); else n_pass++;
    do_reset();
  endtask

  task automatic test_single_read();
    do_reset();
    mem_lat = 1;
    bus.mem_gnt_i = 1'b1;
    clear_logs();
    lq0.push_back('{32'h0011_0000, 1'b1, 4'hF, 32'h0});
    drive_inputs();
    repeat (3) tick();
    n_chk++; if (gnt_log[0] !== 2'b01) $display("FAIL single_gnt: got %b expected 01", gnt_log[0]); else n_pass++;
    n_chk++; if (rv_log[1] !== 2'b01) $display("FAIL single_rvalid: got %b expected 01", rv_log[1]); else n_pass++;
    n_chk++; if (rdata_log[1][31:0] !== init_word(32'h0011_0000))
      $display("FAIL single_rdata: got %h expected %h", rdata_log[1][31:0], init_word(32'h0011_0000)); else n_pass++;
    n_chk++; if (outst_log[1] !== 2'd1) $display("FAIL single_outst1: got %0d expected 1", outst_log[1]); else n_pass++;
    n_chk++; if (outst_log[2] !== 2'd0) $display("FAIL single_outst0: got %0d expected 0", outst_log[2]); else n_pass++;
  endtask

  task automatic test_fairness();
    do_reset();
    mem_lat = 1;
    bus.mem_gnt_i = 1'b1;
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      lq0.push_back('{32'h0000_1000 + 32'(4*i), 1'b1, 4'hF, 32'h0});
      lq1.push_back('{32'h0000_2000 + 32'(4*i), 1'b1, 4'hF, 32'h0});
    end
    drive_inputs();
    repeat (6) tick();
    for (int i = 0; i < 6; i++) begin
      n_chk++;
      if (gnt_log[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10))
        $display("FAIL fair_gnt[%0d]: got %b expected %b", i, gnt_log[i], (i % 2 == 0) ? 2'b01 : 2'b10);
      else n_pass++;
    end
    drain();
  endtask

  task automatic test_back_pressure();
    logic [1:0] exp_g[6];
    logic [1:0] exp_o[6];
    exp_g = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00};
    exp_o = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2};
    do_reset();
    mem_lat = 4;
    bus.mem_gnt_i = 1'b1;
    clear_logs();
    for (int i = 0; i < 3; i++) lq0.push_back('{32'h0000_0100 + 32'(4*i), 1'b1, 4'hF, 32'h0});
    drive_inputs();
    repeat (6) tick();
    for (int i = 0; i < 6; i++) begin
      n_chk++;
      if (gnt_log[i] !== exp_g[i]) $display("FAIL bp_gnt[%0d]: got %b expected %b", i, gnt_log[i], exp_g[i]);
      else n_pass++;
      n_chk++;
      if (outst_log[i] !== exp_o[i]) $display("FAIL bp_outst[%0d]: got %0d expected %0d", i, outst_log[i], exp_o[i]);
      else n_pass++;
    end
    n_chk++; if (rv_log[4] !== 2'b01) $display("FAIL bp_retire: got %b expected 01", rv_log[4]); else n_pass++;
    drain();
    mem_lat = 1;
  endtask

  task automatic test_routing();
    logic [1:0]    seq[$];
    logic [DW-1:0] last1;
    do_reset();
    mem_lat = 1;
    bus.mem_gnt_i = 1'b1;
    clear_logs();
    lq0.push_back('{32'h0000_0000, 1'b1, 4'hF, 32'h0});
    lq1.push_back('{32'h0000_0004, 1'b0, 4'b0101, 32'hFACE_BACE});
    lq1.push_back('{32'h0000_0004, 1'b1, 4'hF, 32'h0});
    drive_inputs();
    drain();
    last1 = '0;
    foreach (rv_log[i]) begin
      if (rv_log[i] != 2'b00) seq.push_back(rv_log[i]);
      if (rv_log[i] == 2'b10) last1 = rdata_log[i][63:32];
    end
    n_chk++; if (seq.size() != 3) $display("FAIL route_count: got %0d expected 3", seq.size()); else n_pass++;
    n_chk++; if (seq[0] !== 2'b01) $display("FAIL route_seq0: got %b expected 01", seq[0]); else n_pass++;
    n_chk++; if (seq[1] !== 2'b10) $display("FAIL route_seq1: got %b expected 10", seq[1]); else n_pass++;
    n_chk++; if (seq[2] !== 2'b10) $display("FAIL route_seq2: got %b expected 10", seq[2]); else n_pass++;
    n_chk++; if (last1 !== 32'h5ACE_5ACE) $display("FAIL route_rdata: got %h expected 5ace5ace", last1); else n_pass++;
  endtask

  task automatic test_stall();
    do_reset();
    mem_lat = 1;
    bus.mem_gnt_i = 1'b1;
    lq0.push_back('{32'h0000_0200, 1'b1, 4'hF, 32'h0});
    drive_inputs();
    drain();
    bus.mem_gnt_i = 1'b0;
    lq0.push_back('{32'h0000_0300, 1'b1, 4'hF, 32'h0});
    lq1.push_back('{32'h0000_0400, 1'b1, 4'hF, 32'h0});
    drive_inputs();
    clear_logs();
    repeat (5) tick();
    bus.mem_gnt_i = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (gnt_log[i] !== 2'b00) $display("FAIL stall_gnt[%0d]: got %b expected 00", i, gnt_log[i]);
      else n_pass++;
    end
    n_chk++; if (gnt_log[5] !== 2'b10) $display("FAIL stall_first: got %b expected 10", gnt_log[5]); else n_pass++;
    drain();
  endtask

  task automatic test_spurious_reset();
    do_reset();
    mem_lat = 1;
    bus.mem_gnt_i = 1'b1;
    clear_logs();
    spur = 1'b1;
    repeat (4) tick();
    n_chk++; if (rv_log[0] !== 2'b00) $display("FAIL spur_rvalid: got %b expected 00", rv_log[0]); else n_pass++;
    n_chk++; if (err_log[1] !== 1'b1) $display("FAIL spur_err: got %b expected 1", err_log[1]); else n_pass++;
    n_chk++; if (err_log[3] !== 1'b1) $display("FAIL spur_sticky: got %b expected 1", err_log[3]); else n_pass++;
    mem_lat = 4;
    for (int i = 0; i < 3; i++) lq0.push_back('{32'h0000_0500 + 32'(4*i), 1'b1, 4'hF, 32'h0});
    drive_inputs();
    repeat (2) tick();
    #2;
    rst_ni = 1'b0;
    #1;
    n_chk++; if (outst_o !== 2'd0) $display("FAIL arst_outst: got %0d expected 0", outst_o); else n_pass++;
    n_chk++; if (err_o !== 1'b0) $display("FAIL arst_err: got %b expected 0", err_o); else n_pass++;
    n_chk++; if (bus.gnt_o !== 2'b00) $display("FAIL arst_gnt: got %b expected 00", bus.gnt_o); else n_pass++;
    n_chk++; if (bus.mem_req_o !== 1'b0) $display("FAIL arst_mem_req: got %b expected 0", bus.mem_req_o); else n_pass++;
    do_reset();
    mem_lat = 1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_read();
    test_fairness();
    test_back_pressure();
    test_routing();
    test_stall();
    test_spurious_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
